// File: rtl/axis_ask_uart_pkg.sv
// Shared definitions for the ASK UART transmit cores.
// Holds the serialiser state encoding, parity-mode constants and a helper
// that reports whether a parity mode emits a parity bit.
package axis_ask_uart_pkg;

  localparam int unsigned PAR_W = 2;

  // Serialiser states, one per line phase of a UART frame.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Parity modes as seen on cfg_parity; code 3 also means no parity.
  localparam logic [PAR_W-1:0] PAR_NONE = PAR_W'(0);
  localparam logic [PAR_W-1:0] PAR_EVEN = PAR_W'(1);
  localparam logic [PAR_W-1:0] PAR_ODD  = PAR_W'(2);

  // True when the mode inserts a parity bit between data and stop.
  function automatic logic par_enabled(input logic [PAR_W-1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/ask_uart_sync_fifo.sv
// Single-clock show-ahead FIFO used to buffer words ahead of the serialiser.
// Ports:
//   clk, rst     clock and synchronous active-low reset
//   wr_en/wr_data  write request and word; ignored while full
//   rd_en        pop the head word; ignored while empty
//   rd_data_c    head word, combinational from the read pointer
//   full_c       combinational, level equals depth
//   empty_c      combinational, level equals zero
//   level        registered count of words held, 0..2**AW
module ask_uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data_c,
  output logic             full_c,
  output logic             empty_c,
  output logic [AW:0]      level
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned LVL_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  // Flags derive from the registered level, so a fresh write is not
  // visible to the reader until the following cycle.
  assign full_c    = (level == LVL_W'(DEPTH));
  assign empty_c   = (level == '0);
  assign wr_ok     = wr_en & ~full_c;
  assign rd_ok     = rd_en & ~empty_c;
  assign rd_data_c = mem[rd_ptr];

  // Storage array; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({wr_ok, rd_ok})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/axis_ask_uart_tx_cfg.sv
// AXI-Stream to ASK-modulated UART transmitter with runtime frame config.
// Words are buffered in a FIFO, then sent LSB-first as start/data/parity/stop
// frames; the line level is mapped to programmable ASK amplitude codes.
// Ports:
//   clk, rst         clock and synchronous active-low reset
//   i_tdata/i_tvalid/i_tready  input stream; i_tready = FIFO not full
//   cfg_clkdiv       clk cycles per bit (0 behaves as 1)
//   cfg_parity       0/3 none, 1 even, 2 odd
//   cfg_stop2        two stop bits when set
//   cfg_mark_level   ASK code for line = 1
//   cfg_space_level  ASK code for line = 0
//   fifo_level       words buffered
//   busy             frame in progress
//   baudclk          one-cycle pulse at the last cycle of each bit
//   ask_tx           registered ASK amplitude code
module axis_ask_uart_tx_cfg
  import axis_ask_uart_pkg::*;
#(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned FIFO_AW      = 4,
  parameter int unsigned ASK_WIDTH    = 2,
  parameter int unsigned CLKDIV_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_BITS-1:0]    i_tdata,
  input  logic                    i_tvalid,
  output logic                    i_tready,
  input  logic [CLKDIV_WIDTH-1:0] cfg_clkdiv,
  input  logic [PAR_W-1:0]        cfg_parity,
  input  logic                    cfg_stop2,
  input  logic [ASK_WIDTH-1:0]    cfg_mark_level,
  input  logic [ASK_WIDTH-1:0]    cfg_space_level,
  output logic [FIFO_AW:0]        fifo_level,
  output logic                    busy,
  output logic                    baudclk,
  output logic [ASK_WIDTH-1:0]    ask_tx
);

  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  // FIFO interface
  logic [DATA_BITS-1:0] fifo_rd_data;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 wr_en;
  logic                 pop;

  // Serialiser state and frame-latched configuration
  tx_state_e             state_q, state_d;
  logic [CLKDIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
  logic                  stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic [CLKDIV_WIDTH-1:0] div_q, div_d;
  logic [PAR_W-1:0]      par_q, par_d;
  logic                  stop2_q, stop2_d;
  logic [ASK_WIDTH-1:0]  mark_q, mark_d;
  logic [ASK_WIDTH-1:0]  space_q, space_d;

  // Next values of the registered outputs
  logic                  bit_end;
  logic                  line_d;
  logic [ASK_WIDTH-1:0]  ask_d;
  logic                  busy_d;
  logic                  baud_d;

  assign i_tready = ~fifo_full;
  assign wr_en    = i_tvalid & ~fifo_full;
  assign bit_end  = (cnt_q == div_q - CLKDIV_WIDTH'(1));

  ask_uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (i_tdata),
    .rd_en     (pop),
    .rd_data_c (fifo_rd_data),
    .full_c    (fifo_full),
    .empty_c   (fifo_empty),
    .level     (fifo_level)
  );

  // Next-state, pop/latch control and next values of the registered outputs.
  // Outputs are registered from next-state so ask_tx lines up with state_q.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    data_d     = data_q;
    div_d      = div_q;
    par_d      = par_q;
    stop2_d    = stop2_q;
    mark_d     = mark_q;
    space_d    = space_q;
    pop        = 1'b0;
    line_d     = 1'b1;
    ask_d      = cfg_mark_level;
    busy_d     = 1'b0;
    baud_d     = 1'b0;

    if (state_q != ST_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CLKDIV_WIDTH'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
            state_d    = par_enabled(par_q) ? ST_PARITY : ST_STOP;
            stop_idx_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d    = ST_STOP;
          stop_idx_d = 1'b0;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (stop2_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Pop latches the word and a snapshot of the configuration for one frame.
    if (pop) begin
      state_d = ST_START;
      cnt_d   = '0;
      data_d  = fifo_rd_data;
      div_d   = (cfg_clkdiv == '0) ? CLKDIV_WIDTH'(1) : cfg_clkdiv;
      par_d   = cfg_parity;
      stop2_d = cfg_stop2;
      mark_d  = cfg_mark_level;
      space_d = cfg_space_level;
    end

    unique case (state_d)
      ST_START:  line_d = 1'b0;
      ST_DATA:   line_d = data_d[bit_idx_d];
      ST_PARITY: line_d = (par_d == PAR_ODD) ? ~(^data_d) : ^data_d;
      default:   line_d = 1'b1;
    endcase

    busy_d = (state_d != ST_IDLE);
    baud_d = busy_d && (cnt_d == div_d - CLKDIV_WIDTH'(1));
    if (busy_d) begin
      ask_d = line_d ? mark_d : space_d;
    end
  end

  // State, timer, latched config and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      data_q     <= '0;
      div_q      <= CLKDIV_WIDTH'(1);
      par_q      <= PAR_NONE;
      stop2_q    <= 1'b0;
      mark_q     <= '0;
      space_q    <= '0;
      ask_tx     <= cfg_mark_level;
      busy       <= 1'b0;
      baudclk    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      data_q     <= data_d;
      div_q      <= div_d;
      par_q      <= par_d;
      stop2_q    <= stop2_d;
      mark_q     <= mark_d;
      space_q    <= space_d;
      ask_tx     <= ask_d;
      busy       <= busy_d;
      baudclk    <= baud_d;
    end
  end

endmodule

// File: tb/tb_axis_ask_uart_tx_cfg.sv
// Directed self-checking bench for axis_ask_uart_tx_cfg.
module tb_axis_ask_uart_tx_cfg;

  localparam int unsigned DATA_BITS    = 8;
  localparam int unsigned FIFO_AW      = 2;
  localparam int unsigned ASK_WIDTH    = 2;
  localparam int unsigned CLKDIV_WIDTH = 16;

  logic                    clk;
  logic                    rst;
  logic [DATA_BITS-1:0]    i_tdata;
  logic                    i_tvalid;
  logic                    i_tready;
  logic [CLKDIV_WIDTH-1:0] cfg_clkdiv;
  logic [1:0]              cfg_parity;
  logic                    cfg_stop2;
  logic [ASK_WIDTH-1:0]    cfg_mark_level;
  logic [ASK_WIDTH-1:0]    cfg_space_level;
  logic [FIFO_AW:0]        fifo_level;
  logic                    busy;
  logic                    baudclk;
  logic [ASK_WIDTH-1:0]    ask_tx;

  int checks;
  int failures;

  logic [ASK_WIDTH-1:0] cap_ask  [0:255];
  logic                 cap_busy [0:255];
  logic                 cap_baud [0:255];

  axis_ask_uart_tx_cfg #(
    .DATA_BITS    (DATA_BITS),
    .FIFO_AW      (FIFO_AW),
    .ASK_WIDTH    (ASK_WIDTH),
    .CLKDIV_WIDTH (CLKDIV_WIDTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_tdata         (i_tdata),
    .i_tvalid        (i_tvalid),
    .i_tready        (i_tready),
    .cfg_clkdiv      (cfg_clkdiv),
    .cfg_parity      (cfg_parity),
    .cfg_stop2       (cfg_stop2),
    .cfg_mark_level  (cfg_mark_level),
    .cfg_space_level (cfg_space_level),
    .fifo_level      (fifo_level),
    .busy            (busy),
    .baudclk         (baudclk),
    .ask_tx          (ask_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Record outputs for the current cycle, then advance one clock.
  task automatic capture(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      cap_ask[start+i]  = ask_tx;
      cap_busy[start+i] = busy;
      cap_baud[start+i] = baudclk;
      tick();
    end
  endtask

  // Reference line value for bit slot b of a frame (0 = start bit).
  function automatic logic frame_bit(input logic [7:0] w, input logic [1:0] par, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return w[b-1];
    if (b == 9 && (par == 2'd1 || par == 2'd2)) return (par == 2'd1) ? ^w : ~(^w);
    return 1'b1;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    cfg_mark_level = 2'b01;
    tick();
    tick();
    checks++; if (ask_tx !== 2'b01) begin failures++; $display("FAIL reset_ask got=%0h exp=1", ask_tx); end
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    checks++; if (i_tready !== 1'b1) begin failures++; $display("FAIL reset_tready got=%b exp=1", i_tready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (baudclk !== 1'b0) begin failures++; $display("FAIL reset_baud got=%b exp=0", baudclk); end
    cfg_mark_level = 2'b11;
    tick();
    checks++; if (ask_tx !== 2'b11) begin failures++; $display("FAIL reset_ask_follow got=%0h exp=3", ask_tx); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic_frame();
    int nbaud;
    logic [1:0] exp;
    cfg_clkdiv = 16'd4; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    cfg_mark_level = 2'b11; cfg_space_level = 2'b00;
    i_tdata = 8'hA5; i_tvalid = 1'b1;
    tick();
    i_tvalid = 1'b0;
    checks++; if (fifo_level !== 3'd1) begin failures++; $display("FAIL basic_level1 got=%0d exp=1", fifo_level); end
    checks++; if (ask_tx !== 2'b11) begin failures++; $display("FAIL basic_pre_start got=%0h exp=3", ask_tx); end
    tick();
    capture(0, 41);
    nbaud = 0;
    for (int i = 0; i < 40; i++) begin
      exp = frame_bit(8'hA5, 2'd0, i / 4) ? 2'b11 : 2'b00;
      checks++; if (cap_ask[i] !== exp) begin failures++; $display("FAIL basic_ask[%0d] got=%0h exp=%0h", i, cap_ask[i], exp); end
      checks++; if (cap_busy[i] !== 1'b1) begin failures++; $display("FAIL basic_busy[%0d] got=%b exp=1", i, cap_busy[i]); end
      if (cap_baud[i] === 1'b1) nbaud++;
    end
    checks++; if (nbaud != 10) begin failures++; $display("FAIL basic_baud_count got=%0d exp=10", nbaud); end
    checks++; if (cap_baud[3] !== 1'b1) begin failures++; $display("FAIL basic_baud_first got=%b exp=1", cap_baud[3]); end
    checks++; if (cap_busy[40] !== 1'b0) begin failures++; $display("FAIL basic_busy_end got=%b exp=0", cap_busy[40]); end
    checks++; if (cap_ask[40] !== 2'b11) begin failures++; $display("FAIL basic_idle_mark got=%0h exp=3", cap_ask[40]); end
  endtask

  task automatic test_parity_stop2();
    logic [1:0] exp;
    cfg_clkdiv = 16'd1; cfg_stop2 = 1'b1;
    cfg_mark_level = 2'b10; cfg_space_level = 2'b01;
    for (int p = 1; p <= 2; p++) begin
      cfg_parity = 2'(p);
      i_tdata = 8'h07; i_tvalid = 1'b1;
      tick();
      i_tvalid = 1'b0;
      tick();
      capture(0, 13);
      for (int i = 0; i < 12; i++) begin
        exp = frame_bit(8'h07, 2'(p), i) ? 2'b10 : 2'b01;
        checks++; if (cap_ask[i] !== exp) begin failures++; $display("FAIL par%0d_ask[%0d] got=%0h exp=%0h", p, i, cap_ask[i], exp); end
        checks++; if (cap_busy[i] !== 1'b1) begin failures++; $display("FAIL par%0d_busy[%0d] got=%b exp=1", p, i, cap_busy[i]); end
      end
      exp = (p == 1) ? 2'b10 : 2'b01;
      checks++; if (cap_ask[9] !== exp) begin failures++; $display("FAIL par%0d_bit got=%0h exp=%0h", p, cap_ask[9], exp); end
      checks++; if (cap_busy[12] !== 1'b0) begin failures++; $display("FAIL par%0d_len got=%b exp=0", p, cap_busy[12]); end
      checks++; if (cap_ask[12] !== 2'b10) begin failures++; $display("FAIL par%0d_idle got=%0h exp=2", p, cap_ask[12]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [3];
    logic [1:0] exp;
    words[0] = 8'h5A; words[1] = 8'h3C; words[2] = 8'hFF;
    cfg_clkdiv = 16'd2; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    cfg_mark_level = 2'b11; cfg_space_level = 2'b00;
    i_tvalid = 1'b1; i_tdata = words[0];
    tick();
    i_tdata = words[1];
    tick();
    i_tdata = words[2];
    capture(0, 1);
    i_tvalid = 1'b0;
    capture(1, 60);
    for (int i = 0; i < 60; i++) begin
      exp = frame_bit(words[i/20], 2'd0, (i % 20) / 2) ? 2'b11 : 2'b00;
      checks++; if (cap_ask[i] !== exp) begin failures++; $display("FAIL b2b_ask[%0d] got=%0h exp=%0h", i, cap_ask[i], exp); end
      checks++; if (cap_busy[i] !== 1'b1) begin failures++; $display("FAIL b2b_busy[%0d] got=%b exp=1", i, cap_busy[i]); end
    end
    checks++; if (cap_busy[60] !== 1'b0) begin failures++; $display("FAIL b2b_busy_end got=%b exp=0", cap_busy[60]); end
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL b2b_level got=%0d exp=0", fifo_level); end
  endtask

  task automatic test_config_isolation();
    logic [1:0] exp;
    cfg_clkdiv = 16'd4; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    cfg_mark_level = 2'b11; cfg_space_level = 2'b00;
    i_tvalid = 1'b1; i_tdata = 8'hA5;
    tick();
    i_tdata = 8'h3C;
    tick();
    i_tvalid = 1'b0;
    capture(0, 10);
    cfg_clkdiv = 16'd8;
    capture(10, 111);
    for (int i = 0; i < 120; i++) begin
      if (i < 40) exp = frame_bit(8'hA5, 2'd0, i / 4) ? 2'b11 : 2'b00;
      else        exp = frame_bit(8'h3C, 2'd0, (i - 40) / 8) ? 2'b11 : 2'b00;
      checks++; if (cap_ask[i] !== exp) begin failures++; $display("FAIL cfgiso_ask[%0d] got=%0h exp=%0h", i, cap_ask[i], exp); end
    end
    checks++; if (cap_busy[120] !== 1'b0) begin failures++; $display("FAIL cfgiso_busy_end got=%b exp=0", cap_busy[120]); end
    checks++; if (cap_busy[119] !== 1'b1) begin failures++; $display("FAIL cfgiso_busy_last got=%b exp=1", cap_busy[119]); end

    cfg_clkdiv = 16'd0;
    i_tvalid = 1'b1; i_tdata = 8'h55;
    tick();
    i_tvalid = 1'b0;
    tick();
    capture(0, 11);
    for (int i = 0; i < 10; i++) begin
      exp = frame_bit(8'h55, 2'd0, i) ? 2'b11 : 2'b00;
      checks++; if (cap_ask[i] !== exp) begin failures++; $display("FAIL div0_ask[%0d] got=%0h exp=%0h", i, cap_ask[i], exp); end
      checks++; if (cap_baud[i] !== 1'b1) begin failures++; $display("FAIL div0_baud[%0d] got=%b exp=1", i, cap_baud[i]); end
    end
    checks++; if (cap_busy[10] !== 1'b0) begin failures++; $display("FAIL div0_len got=%b exp=0", cap_busy[10]); end
  endtask

  task automatic test_backpressure();
    int acc;
    cfg_clkdiv = 16'd100; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    acc = 0;
    i_tvalid = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      if (i_tready) acc++;
      if (c == 19) begin
        checks++; if (acc != 5) begin failures++; $display("FAIL bp_accepted got=%0d exp=5", acc); end
        checks++; if (fifo_level !== 3'd4) begin failures++; $display("FAIL bp_level got=%0d exp=4", fifo_level); end
        checks++; if (i_tready !== 1'b0) begin failures++; $display("FAIL bp_tready got=%b exp=0", i_tready); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bp_busy got=%b exp=1", busy); end
      end
      i_tdata = 8'(acc);
      tick();
    end
    checks++; if (acc != 6) begin failures++; $display("FAIL bp_accepted_after got=%0d exp=6", acc); end
    checks++; if (fifo_level !== 3'd4) begin failures++; $display("FAIL bp_level_after got=%0d exp=4", fifo_level); end
    i_tvalid = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset_midframe();
    int viol;
    cfg_clkdiv = 16'd4; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    cfg_mark_level = 2'b11; cfg_space_level = 2'b00;
    i_tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_tdata = 8'(8'h10 + i);
      tick();
    end
    i_tvalid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    checks++; if (fifo_level !== 3'd3) begin failures++; $display("FAIL rstmid_pre_level got=%0d exp=3", fifo_level); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_pre_busy got=%b exp=1", busy); end
    rst = 1'b0;
    tick();
    checks++; if (ask_tx !== 2'b11) begin failures++; $display("FAIL rstmid_ask got=%0h exp=3", ask_tx); end
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL rstmid_level got=%0d exp=0", fifo_level); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if (i_tready !== 1'b1) begin failures++; $display("FAIL rstmid_tready got=%b exp=1", i_tready); end
    rst = 1'b1;
    viol = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (busy !== 1'b0 || ask_tx !== 2'b11) viol++;
    end
    checks++; if (viol != 0) begin failures++; $display("FAIL rstmid_no_frames got=%0d exp=0", viol); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; i_tdata = '0; i_tvalid = 1'b0;
    cfg_clkdiv = 16'd4; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    cfg_mark_level = 2'b11; cfg_space_level = 2'b00;
    test_reset();
    test_basic_frame();
    test_parity_stop2();
    test_back_to_back();
    test_config_isolation();
    test_backpressure();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_ask_uart_tx_cfg.md
# axis_ask_uart_tx_cfg

Parametrised AXI-Stream to ASK-modulated UART transmitter, the next-generation TX path for the ASK link. Words accepted on a ready/valid stream are buffered in an internal FIFO and serialised LSB-first into UART frames. Frame format (data width, parity, stop bits) and baud divisor are runtime-configurable. Line state maps to programmable multi-bit ASK amplitude codes on `ask_tx` for the modulator/DAC front end.

## Interface
- `DATA_BITS`, 8: payload bits per frame, legal 5..9.
- `FIFO_AW`, 4: FIFO address width; depth = 2**FIFO_AW.
- `ASK_WIDTH`, 2: width of the ASK amplitude code.
- `CLKDIV_WIDTH`, 16: width of the baud divisor.

- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-low reset.
- `i_tdata`  in  DATA_BITS  payload word.
- `i_tvalid`  in  1  payload valid.
- `i_tready`  out  1  high when the FIFO is not full.
- `cfg_clkdiv`  in  CLKDIV_WIDTH  clk cycles per bit; 0 is treated as 1.
- `cfg_parity`  in  2  0 = none, 1 = even, 2 = odd, 3 = none.
- `cfg_stop2`  in  1  1 = two stop bits.
- `cfg_mark_level`  in  ASK_WIDTH  code driven for line = 1.
- `cfg_space_level`  in  ASK_WIDTH  code driven for line = 0.
- `fifo_level`  out  FIFO_AW+1  words held, 0..2**FIFO_AW.
- `busy`  out  1  a frame is in progress.
- `baudclk`  out  1  one-cycle pulse at the end of each bit period.
- `ask_tx`  out  ASK_WIDTH  ASK amplitude code.

## Operation
- Write handshake: a word is written on any cycle with `i_tvalid & i_tready`. `i_tready = ~full`, combinational from FIFO state. No bypass: a word written into an empty FIFO is popped no earlier than the next cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: line = 1. If the FIFO is non-empty, pop one word and latch the word, `cfg_clkdiv`, `cfg_parity`, `cfg_stop2` and both level codes. Then go to START.
  - START: line = 0 for one bit period, then go to DATA.
  - DATA: line = data[bit_idx], with bit_idx running 0..DATA_BITS-1. After the last bit, go to PARITY if parity is enabled, otherwise go to STOP.
  - PARITY: even parity transmits ^data; odd parity transmits ~^data. One bit period, then go to STOP.
  - STOP: line = 1 for one or two bit periods. At the end of the final stop period: if the FIFO is non-empty, pop and go straight to START with the config re-latched, giving zero idle gap; otherwise go to IDLE.
- Bit timer: a counter runs 0..div-1, where div = max(latched clkdiv, 1). `baudclk` pulses on the cycle the counter equals div-1.
- Frame length is exactly (1 + DATA_BITS + P + S) × div cycles, where P = 1 if parity is enabled (else 0) and S = 1 or 2.
- Config changes mid-frame have no effect until the next latch.
- `ask_tx` is registered and equals `line ? mark : space`. In IDLE the live `cfg_mark_level` is used, with one cycle of lag; during a frame the latched codes are used.
- `busy` is high from the cycle after the pop through the last stop-bit cycle, and stays high across back-to-back frames.
- `fifo_level` updates one cycle after each write or pop. A simultaneous write and pop leaves it unchanged.

## Timing
- Reset values while `rst` is low: FSM = IDLE, FIFO empty, `fifo_level` = 0, `i_tready` = 1, `busy` = 0, `baudclk` = 0, `ask_tx` <= `cfg_mark_level`.
- Reset asserted mid-frame aborts the frame on the next clock edge. Buffered words are discarded. No partial stop bit is emitted; the line returns to mark.
- Latency: a write into an empty, idle block at cycle t is popped at t+1, and `ask_tx` shows the space code (start bit) from t+2.
- Full FIFO: `i_tready` goes low on the cycle after the level reaches 2**FIFO_AW. It returns high on the cycle after the pop.

## Structure
- Shared package/header `axis_ask_uart_pkg`: the FSM state encoding and the parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD). The `simple`/`model` ASK cores can reuse these.
- One sub-module, `ask_uart_sync_fifo`: a synchronous FIFO with width and depth parameters, providing full, empty and level. The serialiser FSM and bit timer stay in the top module.

## Test plan
- Basic frame: DATA_BITS = 8, `cfg_clkdiv` = 4, no parity, one stop bit, mark = 2'b11, space = 2'b00; write 0xA5. Required: line sequence 0,1,0,1,0,0,1,0,1,1 with each bit held 4 cycles (40 cycles total), 10 `baudclk` pulses, start bit at write + 2 cycles.
- Parity and stop bits: write 0x07 with even parity and `cfg_stop2` = 1, `cfg_clkdiv` = 1. Required: parity bit 1, two stop bits, 12-cycle frame. With odd parity the parity bit is 0.
- Back-to-back: write 3 words in consecutive cycles. Required: frames abut with no mark gap between stop and start; `busy` stays high for 3 × 10 × div cycles.
- Backpressure: FIFO_AW = 2, `cfg_clkdiv` = 100, hold `i_tvalid` high. Required: 5 words accepted (1 popped + 4 buffered), `i_tready` low, `fifo_level` = 4; after the first frame ends, exactly one more word is accepted.
- Config isolation: change `cfg_clkdiv` from 4 to 8 mid-frame. Required: the current frame stays at 4 cycles/bit and the next frame uses 8. `cfg_clkdiv` = 0 gives 1 cycle/bit.
- Reset mid-frame: assert `rst` low during DATA with 3 words buffered. Required: next cycle `ask_tx` = mark, `fifo_level` = 0, `busy` = 0, `i_tready` = 1, and no further frames are sent.
